// File: rtl/router_fsm.sv
// router_fsm: packet-level controller for the 1x3 router.
//   Decodes the header destination, waits for the target FIFO to drain, steers write
//   enables into it (tagging the header byte via lfd_state), stalls the source on FIFO
//   full and hands parity load/check off to the register block.
// Ports:
//   i_clock          system clock, all logic on posedge
//   i_resetn         synchronous active-low reset
//   i_pkt_valid      source driving a packet byte this cycle
//   i_data_in[1:0]   header destination field, sampled in decode state
//   i_parity_done    register block has captured the parity byte
//   i_low_pkt_valid  register block: pkt_valid dropped while stalled
//   i_fifo_full[2:0] / i_fifo_empty[2:0] / i_soft_reset[2:0]  per-FIFO flags, FIFO k on bit k
//   o_busy           source must hold its current byte
//   o_detect_add, o_lfd_state, o_ld_state, o_laf_state, o_full_state, o_rst_int_reg
//                    one-per-state decodes
//   o_write_enb_reg  a byte is written this cycle
//   o_write_enb[2:0] one-hot FIFO write enable
module router_fsm (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic       i_pkt_valid,
  input  logic [1:0] i_data_in,
  input  logic       i_parity_done,
  input  logic       i_low_pkt_valid,
  input  logic [2:0] i_fifo_full,
  input  logic [2:0] i_fifo_empty,
  input  logic [2:0] i_soft_reset,
  output logic       o_busy,
  output logic       o_detect_add,
  output logic       o_lfd_state,
  output logic       o_ld_state,
  output logic       o_laf_state,
  output logic       o_full_state,
  output logic       o_rst_int_reg,
  output logic       o_write_enb_reg,
  output logic [2:0] o_write_enb
);

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  logic [2:0] r_state;
  logic [1:0] r_addr;
  logic [2:0] w_state_next;
  logic [1:0] w_addr_next;
  logic [1:0] w_sel;
  logic       w_addr_ok;
  logic [3:0] w_full4;
  logic [3:0] w_empty4;
  logic [3:0] w_soft4;

  // Flags padded to four entries so a 2-bit select never indexes out of range;
  // address 2'b11 reads back as "not empty / not full / no soft reset".
  assign w_full4  = {1'b0, i_fifo_full};
  assign w_empty4 = {1'b0, i_fifo_empty};
  assign w_soft4  = {1'b0, i_soft_reset};

  // Zero-latency decode: the header's field selects the FIFO in the same cycle.
  assign w_sel     = (r_state == DECODE_ADDRESS) ? i_data_in : r_addr;
  assign w_addr_ok = (i_data_in != 2'b11);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    case (r_state)
      DECODE_ADDRESS: begin
        if (i_pkt_valid && w_addr_ok) begin
          w_addr_next  = i_data_in;
          w_state_next = w_empty4[w_sel] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty4[w_sel]) w_state_next = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: w_state_next = LOAD_DATA;
      LOAD_DATA: begin
        // Full wins over end-of-packet so the last byte is not dropped.
        if (w_full4[w_sel])    w_state_next = FIFO_FULL_STATE;
        else if (!i_pkt_valid) w_state_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!w_full4[w_sel]) w_state_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (i_parity_done)        w_state_next = DECODE_ADDRESS;
        else if (i_low_pkt_valid) w_state_next = LOAD_PARITY;
        else                      w_state_next = LOAD_DATA;
      end
      LOAD_PARITY: w_state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        w_state_next = w_full4[w_sel] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: w_state_next = DECODE_ADDRESS;
    endcase
    // Read timeout on the active FIFO abandons the packet.
    if ((r_state != DECODE_ADDRESS) && w_soft4[r_addr]) w_state_next = DECODE_ADDRESS;
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
    end
  end

  assign o_detect_add    = (r_state == DECODE_ADDRESS);
  assign o_lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign o_ld_state      = (r_state == LOAD_DATA);
  assign o_laf_state     = (r_state == LOAD_AFTER_FULL);
  assign o_full_state    = (r_state == FIFO_FULL_STATE);
  assign o_rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign o_busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  assign o_write_enb_reg = (r_state == LOAD_FIRST_DATA) || (r_state == LOAD_DATA) ||
                           (r_state == LOAD_AFTER_FULL) || (r_state == LOAD_PARITY);
  assign o_write_enb     = o_write_enb_reg ? (3'b001 << r_addr) : 3'b000;

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: the stimulus side advances a behavioural packet model
// and queues the expected outputs; a monitor pops and compares once per cycle.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full, fifo_empty, soft_reset;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg;
  logic [2:0] write_enb;

  always #5 clk = ~clk;

  router_fsm dut (
    .i_clock(clk), .i_resetn(resetn), .i_pkt_valid(pkt_valid), .i_data_in(data_in),
    .i_parity_done(parity_done), .i_low_pkt_valid(low_pkt_valid),
    .i_fifo_full(fifo_full), .i_fifo_empty(fifo_empty), .i_soft_reset(soft_reset),
    .o_busy(busy), .o_detect_add(detect_add), .o_lfd_state(lfd_state),
    .o_ld_state(ld_state), .o_laf_state(laf_state), .o_full_state(full_state),
    .o_rst_int_reg(rst_int_reg), .o_write_enb_reg(write_enb_reg), .o_write_enb(write_enb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet phase by name plus the latched destination.
  string m_st   = "DA";
  int    m_addr = 0;

  logic [10:0] sb_q[$];
  string       sb_name[$];

  // Expected output word {busy, detect, lfd, ld, laf, full, rst_int, wr_reg, we[2:0]}.
  function automatic logic [10:0] expect_of(string st, int addr);
    logic wr;
    logic [2:0] we;
    wr = (st == "LFD") || (st == "LD") || (st == "LAF") || (st == "LP");
    we = 3'b000;
    if (wr) we[addr] = 1'b1;
    return {!(st == "DA" || st == "LD"), st == "DA", st == "LFD", st == "LD", st == "LAF",
            st == "FFS", st == "CPE", wr, we};
  endfunction

  // Advance the model over one clock edge with the inputs that were applied.
  task automatic model_step(input logic rn, pv, input logic [1:0] din, input logic pd, lpv,
                            input logic [2:0] ff, fe, sr);
    string nxt;
    int sel;
    if (!rn) begin
      m_st = "DA";
      m_addr = 0;
      return;
    end
    sel = (m_st == "DA") ? int'(din) : m_addr;
    nxt = m_st;
    if (m_st == "DA") begin
      if (pv && din != 2'b11) begin
        nxt = fe[sel] ? "LFD" : "WTE";
        m_addr = sel;
      end
    end else if (m_st == "WTE") begin
      if (fe[sel]) nxt = "LFD";
    end else if (m_st == "LFD") nxt = "LD";
    else if (m_st == "LD") begin
      if (ff[sel]) nxt = "FFS";
      else if (!pv) nxt = "LP";
    end else if (m_st == "FFS") begin
      if (!ff[sel]) nxt = "LAF";
    end else if (m_st == "LAF") nxt = pd ? "DA" : (lpv ? "LP" : "LD");
    else if (m_st == "LP") nxt = "CPE";
    else if (m_st == "CPE") nxt = ff[sel] ? "FFS" : "DA";
    if (m_st != "DA" && sr[m_addr]) nxt = "DA";
    m_st = nxt;
  endtask

  // Apply one cycle of inputs, let the edge pass, then queue the expected result.
  task automatic cyc(input logic rn, pv, input logic [1:0] din, input logic pd, lpv,
                     input logic [2:0] ff, fe, sr);
    resetn = rn; pkt_valid = pv; data_in = din; parity_done = pd; low_pkt_valid = lpv;
    fifo_full = ff; fifo_empty = fe; soft_reset = sr;
    @(posedge clk);
    #1;
    model_step(rn, pv, din, pd, lpv, ff, fe, sr);
    sb_q.push_back(expect_of(m_st, m_addr));
    sb_name.push_back(m_st);
  endtask

  // Common shorthand: running, nothing full/timed out, all FIFOs empty.
  task automatic run(input logic pv, input logic [1:0] din);
    cyc(1'b1, pv, din, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
  endtask

  bit cnt_en = 0;
  int we_cnt = 0;
  int lfd_cnt = 0;

  // Monitor: outputs are Moore, so every cycle presents a response.
  always @(negedge clk) begin
    logic [10:0] act, exp_v;
    string nm;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      nm = sb_name.pop_front();
      act = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
             write_enb_reg, write_enb};
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL outputs@%0t state=%s got=%b want=%b", $time, nm, act, exp_v);
      end
    end
    if (cnt_en) begin
      if (write_enb == 3'b010) we_cnt++;
      if (lfd_state) lfd_cnt++;
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    resetn = 0; pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0;
    fifo_full = 0; fifo_empty = 3'b111; soft_reset = 0;

    // 1. Reset then idle.
    repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    repeat (2) run(1'b0, 2'b00);

    // 2. Header to addr 1 (8'h0D), 3 payload bytes, pkt_valid drops.
    we_cnt = 0; lfd_cnt = 0; cnt_en = 1;
    run(1'b1, 2'b01);
    repeat (3) run(1'b1, 2'b10);
    repeat (3) run(1'b0, 2'b00);
    @(negedge clk); #1;
    cnt_en = 0;
    check_val("addr1_write_cycles", we_cnt, 5);
    check_val("addr1_lfd_cycles", lfd_cnt, 1);

    // 3. Header to addr 2 while FIFO 2 still holds data.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b011, 3'b000);
    repeat (3) cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b011, 3'b000);
    run(1'b1, 2'b00);
    run(1'b1, 2'b00);
    repeat (3) run(1'b0, 2'b00);

    // 4. FIFO 0 fills mid-payload; resume to LD, then again with low_pkt_valid.
    for (int pass = 0; pass < 2; pass++) begin
      run(1'b1, 2'b00);
      run(1'b1, 2'b00);
      run(1'b1, 2'b00);
      repeat (3) cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 3'b111, 3'b000);
      cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
      cyc(1'b1, 1'b0, 2'b00, 1'b0, pass[0], 3'b000, 3'b111, 3'b000);
      repeat (4) run(1'b0, 2'b00);
    end

    // 5. Soft reset on the active FIFO aborts; on another FIFO it is ignored.
    run(1'b1, 2'b01);
    run(1'b1, 2'b01);
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, 3'b010);
    run(1'b0, 2'b00);
    run(1'b1, 2'b01);
    run(1'b1, 2'b01);
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, 3'b001);
    repeat (4) run(1'b0, 2'b00);

    // 6. Invalid destination ignored; reset mid-packet.
    run(1'b1, 2'b11);
    run(1'b1, 2'b11);
    run(1'b1, 2'b10);
    run(1'b1, 2'b10);
    cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    repeat (2) run(1'b0, 2'b00);

    // Random traffic with biased flags.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ff, fe, sr;
      for (int k = 0; k < 3; k++) begin
        ff[k] = ($urandom_range(0, 9) == 0);
        fe[k] = ($urandom_range(0, 3) != 0);
        sr[k] = ($urandom_range(0, 29) == 0);
      end
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ff, fe, sr);
    end

    repeat (2) @(negedge clk);
    #1;
    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
